// File: rtl/seq_execute.sv
`default_nettype none
// ============================================================================
//  Module      : seq_execute
//  Description : Execute stage of the sequential Y86-64 processor.
//                A 64-bit ALU produces valE from icode/ifun and the operands
//                valA, valB and valC. The architectural condition codes
//                (ZF, SF, OF) are held here and updated by OPq instructions.
//                The branch/move condition cnd is evaluated from them for
//                jXX and cmovXX.
//
//  Ports
//    clk    in   1   rising-edge clock; condition codes update on this edge
//    rst    in   1   asynchronous, active-high reset (ZF=1, SF=0, OF=0)
//    icode  in   4   instruction code
//    ifun   in   4   function code
//    valA   in  64   operand A
//    valB   in  64   operand B
//    valC   in  64   constant / displacement
//    valE   out 64   ALU result (combinational)
//    cnd    out  1   condition result (combinational from registered flags)
//    ZF     out  1   registered zero flag
//    OF     out  1   registered overflow flag
//    SF     out  1   registered sign flag
//
//  Revision    : 1.0  initial release
// ============================================================================
module seq_execute (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [63:0] valA,
    input  logic [63:0] valB,
    input  logic [63:0] valC,
    output logic [63:0] valE,
    output logic        cnd,
    output logic        ZF,
    output logic        OF,
    output logic        SF
);

    // ------------------------------------------------------------------
    // Instruction codes
    // ------------------------------------------------------------------
    localparam logic [3:0] c_I_HALT   = 4'h0;
    localparam logic [3:0] c_I_NOP    = 4'h1;
    localparam logic [3:0] c_I_RRMOVQ = 4'h2;
    localparam logic [3:0] c_I_IRMOVQ = 4'h3;
    localparam logic [3:0] c_I_RMMOVQ = 4'h4;
    localparam logic [3:0] c_I_MRMOVQ = 4'h5;
    localparam logic [3:0] c_I_OPQ    = 4'h6;
    localparam logic [3:0] c_I_JXX    = 4'h7;
    localparam logic [3:0] c_I_CALL   = 4'h8;
    localparam logic [3:0] c_I_RET    = 4'h9;
    localparam logic [3:0] c_I_PUSHQ  = 4'hA;
    localparam logic [3:0] c_I_POPQ   = 4'hB;

    // OPq function codes
    localparam logic [3:0] c_ALU_ADD  = 4'h0;
    localparam logic [3:0] c_ALU_SUB  = 4'h1;
    localparam logic [3:0] c_ALU_AND  = 4'h2;
    localparam logic [3:0] c_ALU_XOR  = 4'h3;

    // Condition function codes shared by jXX and cmovXX
    localparam logic [3:0] c_C_YES    = 4'h0;
    localparam logic [3:0] c_C_LE     = 4'h1;
    localparam logic [3:0] c_C_L      = 4'h2;
    localparam logic [3:0] c_C_E      = 4'h3;
    localparam logic [3:0] c_C_NE     = 4'h4;
    localparam logic [3:0] c_C_GE     = 4'h5;
    localparam logic [3:0] c_C_G      = 4'h6;

    // Stack pointer adjustment for call/ret/push/pop
    localparam logic [63:0] c_STACK_STEP = 64'd8;

    // ------------------------------------------------------------------
    // Internal signals
    // ------------------------------------------------------------------
    logic [63:0] w_op_res;    // OPq result, independent of icode
    logic        w_op_of;     // signed overflow of the OPq result
    logic        w_op_valid;  // ifun names a real OPq operation
    logic        w_cc_load;   // condition codes capture on this edge

    logic        r_zf;
    logic        r_sf;
    logic        r_of;

    // ------------------------------------------------------------------
    // OPq datapath. Computed unconditionally so the same result feeds both
    // valE and the condition-code update without duplicating adders.
    // Overflow is judged against valB because the operation is
    // "valB op valA" (Y86 subq computes rB - rA).
    // ------------------------------------------------------------------
    always_comb begin
        w_op_res   = 64'd0;
        w_op_of    = 1'b0;
        w_op_valid = 1'b1;
        case (ifun)
            c_ALU_ADD: begin
                w_op_res = valB + valA;
                w_op_of  = (valA[63] == valB[63]) && (w_op_res[63] != valB[63]);
            end
            c_ALU_SUB: begin
                w_op_res = valB - valA;
                w_op_of  = (valA[63] != valB[63]) && (w_op_res[63] != valB[63]);
            end
            c_ALU_AND: begin
                w_op_res = valB & valA;
            end
            c_ALU_XOR: begin
                w_op_res = valB ^ valA;
            end
            default: begin
                w_op_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // valE selection
    // ------------------------------------------------------------------
    always_comb begin
        valE = 64'd0;
        case (icode)
            c_I_HALT,
            c_I_NOP,
            c_I_JXX:    valE = 64'd0;
            c_I_RRMOVQ: valE = valA;
            c_I_IRMOVQ: valE = valC;
            c_I_RMMOVQ,
            c_I_MRMOVQ: valE = valB + valC;
            c_I_OPQ:    valE = w_op_res;   // zero for undefined ifun
            c_I_CALL,
            c_I_PUSHQ:  valE = valB - c_STACK_STEP;
            c_I_RET,
            c_I_POPQ:   valE = valB + c_STACK_STEP;
            default:    valE = 64'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Condition codes. Only a well-formed OPq updates them; every other
    // instruction, including OPq with an undefined ifun, leaves them alone.
    // ------------------------------------------------------------------
    assign w_cc_load = (icode == c_I_OPQ) && w_op_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zf <= 1'b1;
            r_sf <= 1'b0;
            r_of <= 1'b0;
        end else if (w_cc_load) begin
            r_zf <= (w_op_res == 64'd0);
            r_sf <= w_op_res[63];
            r_of <= w_op_of;
        end
    end

    assign ZF = r_zf;
    assign SF = r_sf;
    assign OF = r_of;

    // ------------------------------------------------------------------
    // Branch / conditional-move condition from the registered flags.
    // ------------------------------------------------------------------
    always_comb begin
        cnd = 1'b0;
        if ((icode == c_I_RRMOVQ) || (icode == c_I_JXX)) begin
            case (ifun)
                c_C_YES: cnd = 1'b1;
                c_C_LE:  cnd = (r_sf ^ r_of) | r_zf;
                c_C_L:   cnd = r_sf ^ r_of;
                c_C_E:   cnd = r_zf;
                c_C_NE:  cnd = ~r_zf;
                c_C_GE:  cnd = ~(r_sf ^ r_of);
                c_C_G:   cnd = ~(r_sf ^ r_of) & ~r_zf;
                default: cnd = 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_execute.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_execute
//  Description : Self-checking bench for seq_execute. Stimulus pushes the
//                expected valE/cnd/flags into a queue; a monitor pops and
//                compares on each falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_execute;

    logic        clk;
    logic        rst;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic [63:0] valE;
    logic        cnd;
    logic        ZF;
    logic        OF;
    logic        SF;

    seq_execute dut (
        .clk   (clk),
        .rst   (rst),
        .icode (icode),
        .ifun  (ifun),
        .valA  (valA),
        .valB  (valB),
        .valC  (valC),
        .valE  (valE),
        .cnd   (cnd),
        .ZF    (ZF),
        .OF    (OF),
        .SF    (SF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] vale;
        logic        cnd;
        logic        zf;
        logic        sf;
        logic        of;
    } exp_t;

    exp_t q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference architectural flags
    logic m_zf, m_sf, m_of;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: valE and cnd from the instruction rules, flags via
    // signed 65-bit arithmetic for overflow.
    task automatic model(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         output logic [63:0] ve, output logic cd,
                         output logic upd, output logic nz, output logic ns, output logic no);
        logic signed [64:0] wide;
        logic lt;
        ve = 64'd0; cd = 1'b0; upd = 1'b0; nz = 1'b0; ns = 1'b0; no = 1'b0;
        wide = '0;
        case (ic)
            4'd2:        ve = a;
            4'd3:        ve = c;
            4'd4, 4'd5:  ve = b + c;
            4'd8, 4'd10: ve = b - 64'd8;
            4'd9, 4'd11: ve = b + 64'd8;
            4'd6: begin
                upd = (fn <= 4'd3);
                if (fn == 4'd0) begin
                    ve = b + a;
                    wide = $signed({b[63], b}) + $signed({a[63], a});
                    no = (wide != $signed({ve[63], ve}));
                end else if (fn == 4'd1) begin
                    ve = b - a;
                    wide = $signed({b[63], b}) - $signed({a[63], a});
                    no = (wide != $signed({ve[63], ve}));
                end else if (fn == 4'd2) ve = b & a;
                else if (fn == 4'd3)     ve = b ^ a;
                nz = (ve == 64'd0);
                ns = ve[63];
            end
            default: ve = 64'd0;
        endcase
        // "less" in the flag sense: negative result without overflow, or
        // positive result that overflowed
        lt = (m_sf != m_of);
        if (ic == 4'd2 || ic == 4'd7) begin
            case (fn)
                4'd0: cd = 1'b1;
                4'd1: cd = lt || m_zf;
                4'd2: cd = lt;
                4'd3: cd = m_zf;
                4'd4: cd = !m_zf;
                4'd5: cd = !lt;
                4'd6: cd = !lt && !m_zf;
                default: cd = 1'b0;
            endcase
        end
    endtask

    // Called just after a rising edge: drive one instruction, push its
    // expectation, then advance one clock and update the model flags.
    task automatic issue(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        exp_t e;
        logic [63:0] ve;
        logic cd, upd, nz, ns, no;
        icode = ic; ifun = fn; valA = a; valB = b; valC = c;
        model(ic, fn, a, b, c, ve, cd, upd, nz, ns, no);
        e.vale = ve; e.cnd = cd; e.zf = m_zf; e.sf = m_sf; e.of = m_of;
        q.push_back(e);
        @(posedge clk);
        if (upd) begin
            m_zf = nz; m_sf = ns; m_of = no;
        end
        #1;
    endtask

    // Reset pulse placed between clock edges; flags must drop immediately.
    task automatic async_reset();
        exp_t e;
        icode = 4'd1; ifun = 4'd0;
        #2 rst = 1'b1;
        m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
        e.vale = 64'd0; e.cnd = 1'b0; e.zf = 1'b1; e.sf = 1'b0; e.of = 1'b0;
        q.push_back(e);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("valE", valE, e.vale);
                check("cnd",  {63'd0, cnd}, {63'd0, e.cnd});
                check("ZF",   {63'd0, ZF},  {63'd0, e.zf});
                check("SF",   {63'd0, SF},  {63'd0, e.sf});
                check("OF",   {63'd0, OF},  {63'd0, e.of});
            end
        end
    end

    function automatic logic [63:0] rnd64();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = 64'd0;
            1:       v = 64'h7FFF_FFFF_FFFF_FFFF;
            2:       v = 64'h8000_0000_0000_0000;
            3:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            4:       v = 64'($urandom_range(0, 20));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        logic [63:0] ra, rb;
        int wait_cnt;
        rst = 1'b1; icode = 4'd1; ifun = 4'd0; valA = '0; valB = '0; valC = '0;
        m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state and condition on reset flags
        issue(4'd7, 4'd3, 64'd0, 64'd0, 64'd0);
        issue(4'd7, 4'd4, 64'd0, 64'd0, 64'd0);
        // Add and subtract
        issue(4'd6, 4'd0, 64'd2, 64'd1, 64'd0);
        issue(4'd6, 4'd1, 64'd7, 64'd1, 64'd0);
        // Conditions with SF=1, OF=0
        issue(4'd7, 4'd0, 64'd0, 64'd0, 64'd0);
        issue(4'd7, 4'd2, 64'd0, 64'd0, 64'd0);
        issue(4'd7, 4'd5, 64'd0, 64'd0, 64'd0);
        issue(4'd7, 4'd6, 64'd0, 64'd0, 64'd0);
        issue(4'd2, 4'd1, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'd0);
        // and/xor and signed overflow
        issue(4'd6, 4'd2, 64'd42, 64'd51, 64'd0);
        issue(4'd6, 4'd3, 64'd5, 64'd5, 64'd0);
        issue(4'd6, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
        issue(4'd7, 4'd1, 64'd0, 64'd0, 64'd0);
        // Stack/memory address arithmetic
        issue(4'd11, 4'd0, 64'd0, 64'd8, 64'd0);
        issue(4'd10, 4'd0, 64'd0, 64'd8, 64'd0);
        issue(4'd9,  4'd0, 64'd0, 64'd2, 64'd0);
        issue(4'd8,  4'd0, 64'd0, 64'd5, 64'd0);
        issue(4'd4,  4'd0, 64'd0, 64'd9, 64'd9);
        issue(4'd3,  4'd0, 64'd0, 64'd0, 64'd13);
        // Non-OPq and undefined OPq leave flags alone
        issue(4'd4,  4'd0, 64'd3, 64'd0, 64'd0);
        issue(4'd8,  4'd0, 64'd0, 64'd0, 64'd0);
        issue(4'd11, 4'd0, 64'd0, 64'd0, 64'd0);
        issue(4'd6,  4'd7, 64'd3, 64'd3, 64'd0);
        issue(4'd7,  4'd0, 64'd0, 64'd0, 64'd0);
        // Asynchronous reset between edges, then normal update resumes
        async_reset();
        issue(4'd6, 4'd1, 64'd1, 64'd0, 64'd0);
        issue(4'd7, 4'd2, 64'd0, 64'd0, 64'd0);

        // Randomized stream
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                async_reset();
            end else begin
                ra = rnd64();
                rb = ($urandom_range(0, 7) == 0) ? ra : rnd64();
                issue(($urandom_range(0, 2) == 0) ? 4'd6 : 4'($urandom_range(0, 15)),
                      ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(0, 7)),
                      ra, rb, rnd64());
            end
        end

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
